// File: rtl/reg_counter_bank.sv
// Bank of independent programmable up/down counters behind a simple
// wr_en/rd_en/addr register bus, one sticky terminal-count interrupt per channel.

module reg_counter_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ctrl,
    input  logic             wr_period,
    input  logic             wr_cnt,
    input  logic             wr_clr,
    input  logic [3:0]       ctrl_d,
    input  logic [CNT_W-1:0] val_d,
    output logic [3:0]       ctrl,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic             en;
    logic             down;
    logic             oneshot;
    logic             terminal;
    logic [CNT_W-1:0] cnt_nxt;

    assign en      = ctrl[0];
    assign down    = ctrl[1];
    assign oneshot = ctrl[2];

    assign terminal = en & (down ? (cnt == '0) : (cnt == period));

    // A terminal one-shot parks on its terminal value; periodic mode reloads.
    always_comb begin
        cnt_nxt = cnt;
        if (terminal) begin
            if (!oneshot) begin
                cnt_nxt = down ? period : '0;
            end
        end else if (en) begin
            cnt_nxt = down ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= ctrl_d;
        end else if (terminal && oneshot) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= '1;
        end else if (wr_period) begin
            period <= val_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_cnt) begin
            cnt <= val_d;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Setting TC wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc <= 1'b0;
        end else if (terminal) begin
            tc <= 1'b1;
        end else if (wr_clr) begin
            tc <= 1'b0;
        end
    end

endmodule

module reg_counter_bank #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq
);

    localparam int CH_W = ADDR_W - 4;

    logic [CH_W-1:0]                ch;
    logic                           acc_ok;
    logic                           wr_mode;
    logic                           rd_mode;
    logic                           sel_ctrl;
    logic                           sel_period;
    logic                           sel_cnt;
    logic                           sel_status;

    logic [NUM_CH-1:0][3:0]         ctrl_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   period_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q;
    logic [NUM_CH-1:0]              tc_q;

    assign ch      = addr[ADDR_W-1:4];
    assign acc_ok  = (addr[1:0] == 2'b00) && (32'(ch) < NUM_CH);
    assign wr_mode = wr_en & ~rd_en;
    assign rd_mode = rd_en & ~wr_en;

    assign sel_ctrl   = (addr[3:2] == 2'd0);
    assign sel_period = (addr[3:2] == 2'd1);
    assign sel_cnt    = (addr[3:2] == 2'd2);
    assign sel_status = (addr[3:2] == 2'd3);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;

        assign hit = wr_mode & acc_ok & (ch == CH_W'(c));

        reg_counter_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_ctrl   (hit & sel_ctrl),
            .wr_period (hit & sel_period),
            .wr_cnt    (hit & sel_cnt),
            .wr_clr    (hit & sel_status & wdata[0]),
            .ctrl_d    (wdata[3:0]),
            .val_d     (wdata[CNT_W-1:0]),
            .ctrl      (ctrl_q[c]),
            .period    (period_q[c]),
            .cnt       (cnt_q[c]),
            .tc        (tc_q[c])
        );

        assign irq[c] = tc_q[c] & ctrl_q[c][3];
    end

    // Read mux: zero unless a clean, in-range read is presented.
    always_comb begin
        rdata = '0;
        if (rd_mode && acc_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch == CH_W'(c)) begin
                    unique case (1'b1)
                        sel_ctrl:   rdata = {28'd0, ctrl_q[c]};
                        sel_period: rdata = 32'(period_q[c]);
                        sel_cnt:    rdata = 32'(cnt_q[c]);
                        sel_status: rdata = {31'd0, tc_q[c]};
                        default:    rdata = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_counter_bank.sv
// Directed scoreboard bench for reg_counter_bank (32-bit and 8-bit
// counter instances).

module tb_reg_counter_bank;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  irq;

    logic        wr8;
    logic        rd8;
    logic [9:0]  addr8;
    logic [31:0] wdata8;
    logic [31:0] rdata8;
    logic [1:0]  irq8;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    reg_counter_bank #(
        .NUM_CH (2),
        .CNT_W  (32),
        .ADDR_W (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    reg_counter_bank #(
        .NUM_CH (2),
        .CNT_W  (8),
        .ADDR_W (10)
    ) dut8 (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr8),
        .rd_en (rd8),
        .addr  (addr8),
        .wdata (wdata8),
        .rdata (rdata8),
        .irq   (irq8)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (got === e)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] e,
                      input string tag);
        exp_q.push_back(e);
        addr  = a;
        rd_en = 1'b1;
        #1;
        check(tag, rdata);
        rd_en = 1'b0;
    endtask

    task automatic chk_irq(input int c, input logic e, input string tag);
        exp_q.push_back({31'd0, e});
        #1;
        check(tag, {31'd0, irq[c]});
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        addr   = '0;
        wdata  = '0;
        wr8    = 1'b0;
        rd8    = 1'b0;
        addr8  = '0;
        wdata8 = '0;

        tick();
        tick();
        rd(10'h004, 32'hFFFF_FFFF, "rst_hold_period");
        rst = 1'b0;

        // reset values
        rd(10'h004, 32'hFFFF_FFFF, "rst_period0");
        rd(10'h000, 32'h0, "rst_ctrl0");
        rd(10'h008, 32'h0, "rst_cnt0");
        rd(10'h00C, 32'h0, "rst_status0");
        rd(10'h014, 32'hFFFF_FFFF, "rst_period1");
        exp_q.push_back(32'h0);
        #1;
        check("rst_irq", {30'd0, irq});
        addr = 10'h004;
        #1;
        exp_q.push_back(32'h0);
        check("idle_rdata", rdata);

        // both strobes: no read data, no write
        addr  = 10'h004;
        wdata = 32'h5;
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        check("both_rdata", rdata);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rd(10'h004, 32'hFFFF_FFFF, "both_nowrite");

        // up wrap on ch0
        wr(10'h004, 32'd3);
        wr(10'h000, 32'h9);
        rd(10'h008, 32'd0, "up_start");
        tick();
        rd(10'h008, 32'd1, "up_1");
        tick();
        rd(10'h008, 32'd2, "up_2");
        tick();
        rd(10'h008, 32'd3, "up_3");
        rd(10'h00C, 32'd0, "up_tc_pre");
        chk_irq(0, 1'b0, "up_irq_pre");
        tick();
        rd(10'h008, 32'd0, "up_wrap");
        rd(10'h00C, 32'd1, "up_tc");
        chk_irq(0, 1'b1, "up_irq");
        wr(10'h00C, 32'd1);
        rd(10'h00C, 32'd0, "up_w1c");
        chk_irq(0, 1'b0, "up_irq_clr");
        rd(10'h008, 32'd1, "up_after_clr");

        // down one-shot on ch1
        wr(10'h018, 32'd2);
        wr(10'h010, 32'h7);
        rd(10'h018, 32'd2, "dn_start");
        tick();
        rd(10'h018, 32'd1, "dn_1");
        tick();
        rd(10'h018, 32'd0, "dn_0");
        tick();
        rd(10'h018, 32'd0, "dn_term");
        rd(10'h010, 32'h6, "dn_ctrl");
        rd(10'h01C, 32'd1, "dn_status");
        chk_irq(1, 1'b0, "dn_irq");
        rd(10'h000, 32'h9, "dn_ch0_ctrl");
        rd(10'h004, 32'd3, "dn_ch0_period");
        tick();
        rd(10'h018, 32'd0, "dn_hold");

        wr(10'h000, 32'h0);
        wr(10'h00C, 32'd1);

        // collisions on ch1
        wr(10'h01C, 32'd1);
        rd(10'h01C, 32'd0, "col_clr");
        wr(10'h014, 32'd2);
        wr(10'h010, 32'h3);
        rd(10'h018, 32'd0, "col_cnt0");
        wr(10'h01C, 32'd1);
        rd(10'h01C, 32'd1, "col_tc_wins");
        rd(10'h018, 32'd2, "col_reload");
        wr(10'h018, 32'h10);
        rd(10'h018, 32'h10, "col_cnt_wins");
        tick();
        rd(10'h018, 32'h0F, "col_resume");

        // PERIOD == 0, up count
        wr(10'h010, 32'h0);
        wr(10'h014, 32'h0);
        wr(10'h018, 32'h0);
        wr(10'h01C, 32'd1);
        rd(10'h01C, 32'd0, "p0_clr");
        wr(10'h010, 32'h1);
        tick();
        rd(10'h018, 32'd0, "p0_cnt");
        rd(10'h01C, 32'd1, "p0_tc");
        wr(10'h01C, 32'd1);
        rd(10'h01C, 32'd1, "p0_tc_again");
        wr(10'h010, 32'h0);

        // decode limits
        wr(10'h020, 32'hAB);
        wr(10'h006, 32'h55);
        rd(10'h000, 32'h0, "dec_ch0_ctrl");
        rd(10'h004, 32'd3, "dec_ch0_period");
        rd(10'h010, 32'h0, "dec_ch1_ctrl");
        rd(10'h014, 32'h0, "dec_ch1_period");
        rd(10'h020, 32'h0, "dec_rd_oor");
        rd(10'h006, 32'h0, "dec_rd_mis");

        // 8-bit instance truncation
        addr8  = 10'h008;
        wdata8 = 32'h1FF;
        wr8    = 1'b1;
        tick();
        wr8 = 1'b0;
        rd8 = 1'b1;
        #1;
        exp_q.push_back(32'hFF);
        check("w8_cnt", rdata8);
        addr8 = 10'h004;
        #1;
        exp_q.push_back(32'hFF);
        check("w8_period", rdata8);
        rd8 = 1'b0;

        // async reset mid-count
        wr(10'h008, 32'd0);
        wr(10'h000, 32'h9);
        repeat (4) tick();
        chk_irq(0, 1'b1, "ar_irq_pre");
        tick();
        rd(10'h008, 32'd1, "ar_cnt_pre");
        #10;
        rst = 1'b1;
        #1;
        rd(10'h008, 32'd0, "ar_cnt");
        rd(10'h004, 32'hFFFF_FFFF, "ar_period");
        rd(10'h000, 32'h0, "ar_ctrl");
        exp_q.push_back(32'h0);
        check("ar_irq", {30'd0, irq});
        tick();
        rst = 1'b0;
        tick();
        rd(10'h008, 32'd0, "ar_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_counter_bank.md
Name: reg_counter_bank

Overview:
- Parametrised bank of NUM_CH independent CNT_W-bit counters, each programmed through a simple wr_en/rd_en/addr register interface.
- Per channel: control register, period register, live count register and sticky status register.
- Sits behind the same bus used by the existing two-register block and drives one interrupt line per channel to the top level.

Parameters:
- NUM_CH, 2, number of counter channels (1..16).
- CNT_W, 32, counter/period width in bits (1..32).
- ADDR_W, 10, bus address width (must satisfy 2^ADDR_W >= NUM_CH*16).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe.
- rd_en  input  1  read strobe.
- addr  input  ADDR_W  byte address.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational.
- irq  output  NUM_CH  per-channel interrupt, irq[c] = STATUS[c].TC & CTRL[c].IE.

Behaviour:
- Address decode: channel c = addr[ADDR_W-1:4], register = addr[3:2]. A valid access needs addr[1:0]==0 and c < NUM_CH. Invalid writes are ignored; invalid reads return 0.
- Register map per channel, base c*0x10:
  - +0x0 CTRL: [0] EN, [1] DOWN, [2] ONESHOT, [3] IE. Reset 0.
  - +0x4 PERIOD: reset all-ones (CNT_W bits).
  - +0x8 CNT: reset 0. A write loads the counter directly.
  - +0xC STATUS: [0] TC, sticky, write-1-to-clear. Reset 0.
- Bus modes: write mode = wr_en & ~rd_en; read mode = rd_en & ~wr_en. Both high, or both low: no write occurs and rdata = 0.
- Reads: rdata is combinational from current register state and zero-extended. Unused CTRL/STATUS bits read 0.
- Writes: take effect at the next rising clk edge. Only the low CNT_W bits of wdata are used for PERIOD and CNT.
- Counting, per cycle when EN=1:
  - DOWN=0: if CNT==PERIOD, terminal; else CNT+1.
  - DOWN=1: if CNT==0, terminal; else CNT-1.
- Terminal event, in the same edge:
  - Set TC.
  - ONESHOT=1: clear EN and hold CNT at the terminal value.
  - ONESHOT=0: reload (up: CNT<=0; down: CNT<=PERIOD).
- EN=0: CNT holds; no terminal events.
- PERIOD==0: an up counter is terminal every cycle with CNT stuck at 0; a down counter reloads 0, also terminal every cycle.
- Simultaneous events:
  - Bus write to CNT beats count/reload in that cycle.
  - Bus write to CTRL beats the ONESHOT auto-clear of EN.
  - TC set beats a W1C clear in the same cycle (TC stays 1).
  - Writing PERIOD mid-count takes effect on the next compare; no reload is forced.
- Channels are fully independent; a write affects only the addressed channel.
- rst asserted at any time: all registers return to reset values asynchronously, irq=0, rdata=0 unless a read is presented (then the reset value of the addressed register).
- Latency: write-to-readback is 1 clk. Count to TC to irq is visible 1 clk after the terminal cycle's edge (irq is combinational from regs).

Test Plan:
- Reset check: rst=1 then release. Read 0x4 -> 0xFFFF_FFFF; read 0x0/0x8/0xC -> 0; irq=0. wr_en=rd_en=1 at 0x4 -> rdata=0 and no write.
- Up wrap: ch0 PERIOD=3, CTRL=0x9 (EN|IE). CNT reads 1,2,3,0 on successive edges. TC=1 and irq[0]=1 after the 3->0 edge. Write 0xC=1 -> TC=0, irq[0]=0.
- Down one-shot: ch1 CNT=2, CTRL=0x7. CNT reads 1, 0, then holds 0. CTRL reads 0x6 (EN cleared), STATUS=1, irq[1]=0 (IE=0). ch0 untouched.
- Collisions: W1C to STATUS on the same edge as a terminal -> TC stays 1. CNT write of 0x10 on a counting edge -> CNT=0x10 next cycle.
- Decode limits with NUM_CH=2: write 0x20 and 0x06 -> no register changes; read 0x20 -> 0. With CNT_W=8, write CNT=0x1FF -> reads 0xFF.
- Async reset mid-count: assert rst between edges while ch0 is counting -> CNT=0, PERIOD=0xFFFF_FFFF, irq=0 immediately without a clk edge.
